// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM state encoding and forwarding-select codes.
// Pure declarations; no clocked logic.
package pipe_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_DRAIN    = 2'd2;
  localparam logic [1:0] ST_HALTED   = 2'd3;

  typedef enum logic [1:0] {
    RUN      = ST_RUN,
    MEM_WAIT = ST_MEM_WAIT,
    DRAIN    = ST_DRAIN,
    HALTED   = ST_HALTED
  } state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // A load still in EX has no data yet, so its EX/MEM path is not a valid source.
  function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem,
                                         input logic ex_load);
    if (hit_ex && !ex_load) return FWD_EXMEM;
    if (hit_mem)            return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/event inputs and stage-control outputs of the pipeline controller.
// master = controller side, slave = pipeline datapath side.
interface pipeline_ctrl_if #(parameter int CNT_W = 16);

  logic             R1_EX, R1_MEM, R2_EX, R2_MEM;
  logic             EX_MemRead, EX_BranchTaken, ID_Halt, Resume;
  logic             MEM_Req, MEM_Ready;
  logic             PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En;
  logic             IFID_Flush, IDEX_Flush;
  logic [1:0]       R1_Fwd, R2_Fwd;
  logic [CNT_W-1:0] Stall_Cnt, Flush_Cnt;
  logic             Halted;

  modport master (
    input  R1_EX, R1_MEM, R2_EX, R2_MEM, EX_MemRead, EX_BranchTaken, ID_Halt, Resume,
    input  MEM_Req, MEM_Ready,
    output PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En, IFID_Flush, IDEX_Flush,
    output R1_Fwd, R2_Fwd, Stall_Cnt, Flush_Cnt, Halted
  );

  modport slave (
    output R1_EX, R1_MEM, R2_EX, R2_MEM, EX_MemRead, EX_BranchTaken, ID_Halt, Resume,
    output MEM_Req, MEM_Ready,
    input  PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En, IFID_Flush, IDEX_Flush,
    input  R1_Fwd, R2_Fwd, Stall_Cnt, Flush_Cnt, Halted
  );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
// One-cycle update latency; no backpressure.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// 5-stage pipeline controller: forwarding, load-use stall, branch flush, memory freeze, halt/drain.
// Stage controls are combinational (zero latency); counters and Halted come from registers.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  pipeline_ctrl_if.master  bus
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t        state, state_nxt;
  logic [DW-1:0] drain_cnt, drain_nxt;
  logic          resume_q, resume_nxt;
  logic [4:0]    en;        // {PC, IFID, IDEX, EXMEM, MEMWB}
  logic          ifid_flush, idex_flush;
  logic [1:0]    r1_fwd, r2_fwd;
  logic          stall_inc, flush_inc;
  logic          mem_stall, load_use, hold;

  assign mem_stall = bus.MEM_Req & ~bus.MEM_Ready;
  assign load_use  = (bus.R1_EX | bus.R2_EX) & bus.EX_MemRead;
  assign hold      = (state == MEM_WAIT) ? ~bus.MEM_Ready : mem_stall;

  always_comb begin
    state_nxt  = state;
    drain_nxt  = drain_cnt;
    resume_nxt = 1'b0;
    en         = 5'b11111;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    r1_fwd     = fwd_sel(bus.R1_EX, bus.R1_MEM, bus.EX_MemRead);
    r2_fwd     = fwd_sel(bus.R2_EX, bus.R2_MEM, bus.EX_MemRead);

    case (state)
      RUN, MEM_WAIT: begin
        if (hold) begin
          en        = 5'b00000;
          state_nxt = MEM_WAIT;
        end else begin
          // The ready cycle of a memory wait behaves exactly like RUN, so deferred events land here.
          state_nxt = RUN;
          if (bus.EX_BranchTaken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
          end else if (load_use) begin
            en[4:3]    = 2'b00;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
          end else if (bus.ID_Halt) begin
            state_nxt = DRAIN;
            drain_nxt = DW'(DRAIN_CYCLES - 1);
          end
          if (state == RUN && resume_q) ifid_flush = 1'b1;
        end
      end
      DRAIN: begin
        if (mem_stall) begin
          en = 5'b00000;
        end else begin
          en[4:3]    = 2'b00;
          idex_flush = 1'b1;
          if (drain_cnt == '0) state_nxt = HALTED;
          else                 drain_nxt = drain_cnt - DW'(1);
        end
      end
      HALTED: begin
        en = 5'b00000;
        if (bus.Resume) begin
          state_nxt  = RUN;
          resume_nxt = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase

    if (!rst_n) begin
      en         = 5'b00000;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      r1_fwd     = FWD_RF;
      r2_fwd     = FWD_RF;
      stall_inc  = 1'b0;
      flush_inc  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      drain_cnt <= '0;
      resume_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      resume_q  <= resume_nxt;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc(stall_inc), .cnt(bus.Stall_Cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc(flush_inc), .cnt(bus.Flush_Cnt)
  );

  assign {bus.PC_En, bus.IFID_En, bus.IDEX_En, bus.EXMEM_En, bus.MEMWB_En} = en;
  assign bus.IFID_Flush = ifid_flush;
  assign bus.IDEX_Flush = idex_flush;
  assign bus.R1_Fwd     = r1_fwd;
  assign bus.R2_Fwd     = r2_fwd;
  assign bus.Halted     = (state == HALTED);

endmodule
